regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port GPR file for the CPU pipeline: NUM_RD combinational read ports,
//   NUM_WR write ports with write-to-read bypass, per-register pending-write scoreboard for
//   decode-stage hazard detection, and a sequential clear engine (reset / soft flush).
//   Sits between ID (reads, busy marking) and WB (writes).
// PARAMETERS
//   DATA_W   32  register width
//   ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//   NUM_RD   2   read ports
//   NUM_WR   2   write ports; higher index = higher priority
//   ZERO_REG 1   1: reg 0 reads 0, writes/busy marks to it ignored
// PORTS
//   clk        in  1               clock, all state on posedge
//   rst        in  1               reset, synchronous, active-high
//   clr_req    in  1               soft clear request (honoured in RUN only)
//   ready      out 1               1 = RUN state, ports live
//   we         in  NUM_WR          write enables
//   waddr      in  NUM_WR*ADDR_W   write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata      in  NUM_WR*DATA_W   write data, port k at [k*DATA_W +: DATA_W]
//   re         in  NUM_RD          read enables
//   raddr      in  NUM_RD*ADDR_W   read addresses, packed as waddr
//   rdata      out NUM_RD*DATA_W   read data, packed as wdata
//   busy_set   in  1               mark busy_addr as having an in-flight producer
//   busy_addr  in  ADDR_W          register to mark
//   rd_pending out NUM_RD          read port i targets a register with unresolved producer
// BEHAVIOUR
//   FSM states INIT, RUN. rst=1 at posedge -> INIT, clr_cnt=0 (rst dominates all).
//   INIT: each cycle regs[clr_cnt]<=0, sb[clr_cnt]<=0, clr_cnt++; after writing DEPTH-1
//     -> RUN next cycle. ready=1 exactly DEPTH cycles after first cycle with rst=0.
//     we/busy_set ignored; rdata=0, rd_pending=0.
//   RUN: clr_req=1 at posedge -> INIT, clr_cnt=0; same-cycle writes/busy_set are dropped.
//   Reset values: ready=0, rdata=0, rd_pending=0 (all outputs derived from state).
//   Write: at posedge, each port k with we[k] writes regs[waddr_k]<=wdata_k. Same address
//     on several ports: highest k wins. Addr 0 dropped when ZERO_REG=1.
//   Read (combinational, 0 latency), port i:
//     !ready or !re[i] -> 0; raddr_i==0 and ZERO_REG -> 0;
//     else highest k with we[k] && waddr_k==raddr_i -> wdata_k (bypass);
//     else regs[raddr_i].
//   Scoreboard sb[DEPTH]: write on port k clears sb[waddr_k]; busy_set sets sb[busy_addr];
//     set and clear on same address same cycle -> set wins (newer producer).
//     ZERO_REG=1: sb[0] stays 0.
//   rd_pending[i] = ready & re[i] & sb[raddr_i] & ~(any we[k] with waddr_k==raddr_i),
//     i.e. a same-cycle bypass resolves the hazard.
//   Address arithmetic: clr_cnt is ADDR_W+1 bits; terminal compare on DEPTH-1, no wrap.
// TESTING
//   1 rst 1 cycle, release -> ready=0 for 32 cycles, 1 on cycle 32; all reads return 0.
//   2 RUN: we[0]=1 waddr0=5 wdata0=0xDEADBEEF, raddr0=5 re0=1 same cycle -> rdata0=0xDEADBEEF
//     (bypass); next cycle with we=0 still 0xDEADBEEF from array.
//   3 we[0],we[1] both addr 7, data 0x11/0x22 -> bypass and stored value 0x22.
//   4 write 0x1234 to reg 0 -> reads of reg 0 return 0; busy_set addr 0 -> rd_pending stays 0.
//   5 busy_set addr 9 -> next cycle re1=1 raddr1=9 gives rd_pending[1]=1; cycle with we[1]=1
//     waddr1=9 -> rd_pending[1]=0 same cycle; busy_set+write addr 9 together -> still pending.
//   6 clr_req mid-run after writing reg 3=0xA5 -> ready=0 next cycle, concurrent write
//     dropped, 32 cycles later ready=1 and reg 3 reads 0; rst asserted mid-INIT restarts count.

Source files
------------

// File: rtl/regfile_mp_if.sv
// ============================================================================
//  Module   : regfile_mp_if
//  Purpose  : Port bundle between the decode/writeback stages and regfile_mp.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   logic                       clr_req;
   logic                       ready;
   logic [NUM_WR-1:0]          we;
   logic [NUM_WR*ADDR_W-1:0]   waddr;
   logic [NUM_WR*DATA_W-1:0]   wdata;
   logic [NUM_RD-1:0]          re;
   logic [NUM_RD*ADDR_W-1:0]   raddr;
   logic [NUM_RD*DATA_W-1:0]   rdata;
   logic                       busy_set;
   logic [ADDR_W-1:0]          busy_addr;
   logic [NUM_RD-1:0]          rd_pending;

   modport master (
      output clr_req, we, waddr, wdata, re, raddr, busy_set, busy_addr,
      input  ready, rdata, rd_pending
   );

   modport slave (
      input  clr_req, we, waddr, wdata, re, raddr, busy_set, busy_addr,
      output ready, rdata, rd_pending
   );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port GPR file with write bypass, pending-write scoreboard
//             and a sequential clear engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave rf_io
);

   localparam int               DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W:0]  C_LAST = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]  C_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              state_q;
   logic [ADDR_W:0]     clr_cnt_q;
   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic                sb_q   [DEPTH];
   logic                ready;

   assign ready       = (state_q == S_RUN);
   assign rf_io.ready = ready;

   // Ascending port loop makes the highest-index write win; busy marks are
   // applied after the clears so a newer producer overrides a retiring one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_INIT;
         clr_cnt_q <= '0;
      end else begin
         case (state_q)
            S_INIT: begin
               regs_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
               sb_q[clr_cnt_q[ADDR_W-1:0]]   <= 1'b0;
               clr_cnt_q                     <= clr_cnt_q + C_ONE;
               if (clr_cnt_q == C_LAST) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (rf_io.clr_req) begin
                  state_q   <= S_INIT;
                  clr_cnt_q <= '0;
               end else begin
                  for (int k = 0; k < NUM_WR; k++) begin
                     if (rf_io.we[k] &&
                         !(ZERO_REG && rf_io.waddr[k*ADDR_W +: ADDR_W] == '0)) begin
                        regs_q[rf_io.waddr[k*ADDR_W +: ADDR_W]] <= rf_io.wdata[k*DATA_W +: DATA_W];
                        sb_q[rf_io.waddr[k*ADDR_W +: ADDR_W]]   <= 1'b0;
                     end
                  end
                  if (rf_io.busy_set && !(ZERO_REG && rf_io.busy_addr == '0)) begin
                     sb_q[rf_io.busy_addr] <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= S_INIT;
               clr_cnt_q <= '0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;
      logic              hit;

      assign ra = rf_io.raddr[i*ADDR_W +: ADDR_W];

      always_comb begin
         rd_val = regs_q[ra];
         hit    = 1'b0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (rf_io.we[k] && rf_io.waddr[k*ADDR_W +: ADDR_W] == ra) begin
               rd_val = rf_io.wdata[k*DATA_W +: DATA_W];
               hit    = 1'b1;
            end
         end
         if (!ready || !rf_io.re[i] || (ZERO_REG && ra == '0)) begin
            rd_val = '0;
         end
      end

      assign rf_io.rdata[i*DATA_W +: DATA_W] = rd_val;
      assign rf_io.rd_pending[i]             = ready & rf_io.re[i] & sb_q[ra] & ~hit;
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Directed self-checking bench for regfile_mp.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) rf ();

   regfile_mp #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1'b1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .rf_io (rf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rf.we       = '0;
      rf.re       = '0;
      rf.busy_set = 1'b0;
      rf.clr_req  = 1'b0;
   endtask

   task automatic wr(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      rf.we[k]                      = 1'b1;
      rf.waddr[k*ADDR_W +: ADDR_W]  = a;
      rf.wdata[k*DATA_W +: DATA_W]  = d;
   endtask

   task automatic rd(input int i, input logic [ADDR_W-1:0] a);
      rf.re[i]                      = 1'b1;
      rf.raddr[i*ADDR_W +: ADDR_W]  = a;
   endtask

   function automatic logic [31:0] rdat(input int i);
      return rf.rdata[i*DATA_W +: DATA_W];
   endfunction

   initial begin
      rf.waddr     = '0;
      rf.wdata     = '0;
      rf.raddr     = '0;
      rf.busy_addr = '0;
      idle();

      // Reset state
      tick();
      rd(0, 5'd5);
      #1;
      chk("rst_ready", 32'(rf.ready), 32'd0);
      chk("rst_rdata", rdat(0), 32'd0);
      chk("rst_pend", 32'(rf.rd_pending), 32'd0);
      rst = 1'b0;

      // Clear sequence: ready rises on the 32nd edge after reset release
      for (int c = 1; c <= 32; c++) begin
         wr(0, 5'd6, 32'hCAFE_0000);
         tick();
         chk("init_ready", 32'(rf.ready), (c == 32) ? 32'd1 : 32'd0);
         if (c == 16) chk("init_rdata", rdat(0), 32'd0);
      end
      idle();
      rd(0, 5'd6);
      #1;
      chk("init_write_ignored", rdat(0), 32'd0);

      // Same-cycle bypass, then stored value
      idle();
      wr(0, 5'd5, 32'hDEAD_BEEF);
      rd(0, 5'd5);
      #1;
      chk("bypass_rd0", rdat(0), 32'hDEAD_BEEF);
      tick();
      idle();
      rd(0, 5'd5);
      #1;
      chk("array_rd0", rdat(0), 32'hDEAD_BEEF);
      rf.re[0] = 1'b0;
      #1;
      chk("re0_low", rdat(0), 32'd0);

      // Two ports on one address: port 1 wins
      idle();
      wr(0, 5'd7, 32'h11);
      wr(1, 5'd7, 32'h22);
      rd(0, 5'd7);
      #1;
      chk("dual_bypass", rdat(0), 32'h22);
      tick();
      idle();
      rd(1, 5'd7);
      #1;
      chk("dual_stored", rdat(1), 32'h22);

      // Register 0 is hardwired
      idle();
      wr(0, 5'd0, 32'h1234);
      rd(0, 5'd0);
      #1;
      chk("zero_bypass", rdat(0), 32'd0);
      tick();
      idle();
      rd(0, 5'd0);
      #1;
      chk("zero_stored", rdat(0), 32'd0);
      rf.busy_set  = 1'b1;
      rf.busy_addr = 5'd0;
      tick();
      idle();
      rd(1, 5'd0);
      #1;
      chk("zero_pend", 32'(rf.rd_pending), 32'd0);

      // Scoreboard
      idle();
      rd(1, 5'd9);
      #1;
      chk("sb9_clean", 32'(rf.rd_pending), 32'd0);
      rf.busy_set  = 1'b1;
      rf.busy_addr = 5'd9;
      tick();
      idle();
      rd(1, 5'd9);
      #1;
      chk("sb9_set", 32'(rf.rd_pending), 32'b10);
      wr(1, 5'd9, 32'h99);
      #1;
      chk("sb9_bypass_resolves", 32'(rf.rd_pending), 32'd0);
      chk("sb9_bypass_data", rdat(1), 32'h99);
      rf.busy_set  = 1'b1;
      rf.busy_addr = 5'd9;
      tick();
      idle();
      rd(1, 5'd9);
      #1;
      chk("sb9_set_wins", 32'(rf.rd_pending), 32'b10);
      wr(0, 5'd9, 32'h98);
      tick();
      idle();
      rd(1, 5'd9);
      #1;
      chk("sb9_cleared", 32'(rf.rd_pending), 32'd0);
      chk("sb9_data", rdat(1), 32'h98);

      // Soft clear with concurrent write/busy that must be dropped
      idle();
      wr(0, 5'd3, 32'hA5);
      tick();
      idle();
      rd(0, 5'd3);
      #1;
      chk("reg3_written", rdat(0), 32'hA5);
      rf.clr_req   = 1'b1;
      wr(0, 5'd4, 32'h77);
      rf.busy_set  = 1'b1;
      rf.busy_addr = 5'd10;
      tick();
      idle();
      chk("clr_ready_low", 32'(rf.ready), 32'd0);
      for (int c = 1; c <= 32; c++) begin
         tick();
         chk("clr_ready", 32'(rf.ready), (c == 32) ? 32'd1 : 32'd0);
      end
      rd(0, 5'd3);
      rd(1, 5'd4);
      #1;
      chk("clr_reg3", rdat(0), 32'd0);
      chk("clr_reg4_dropped", rdat(1), 32'd0);
      rf.raddr[1*ADDR_W +: ADDR_W] = 5'd10;
      #1;
      chk("clr_busy_dropped", 32'(rf.rd_pending), 32'd0);

      // Reset during clear restarts the count
      idle();
      rf.clr_req = 1'b1;
      tick();
      idle();
      for (int c = 0; c < 10; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_ready", 32'(rf.ready), 32'd0);
      for (int c = 1; c <= 32; c++) begin
         tick();
         if (c >= 30) chk("rst_mid_count", 32'(rf.ready), (c == 32) ? 32'd1 : 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
